apb_rr_master: RTL and testbench

// - APB master that shares one APB slave (8-bit, 16-entry RAM) between NREQ local requesters.
// - Round-robin arbitration, full SETUP/ACCESS sequencing, pready wait with timeout.
// - Returns read data and error per transfer.
// - Sits between the requesting engines and the APB slave; it is the only APB master on that bus.

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/apb_rr_master.sv | 162 ++++++++++++++++
 tb/tb_apb_rr_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and bus constants for the round-robin APB master.
package apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // k runs 1..NREQ so the last-granted requester is considered last
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one slave between NREQ requesters; round-robin grant,
// SETUP/ACCESS sequencing with a pready timeout, one response pulse per transfer.
import apb_pkg::*;

module apb_rr_master #(
    parameter int NREQ    = 2,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              presetn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AW-1:0]     paddr,
    output logic [DW-1:0]     pwdata,
    input  logic [DW-1:0]     prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] req_ready_d, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_d, pwdata_d;
    logic [AW-1:0]   paddr_d;
    logic            rsp_err_d, psel_d, penable_d, pwrite_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            done;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            gidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic; every output is the registered copy of its _d.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        psel_d      = psel;
        penable_d   = penable;
        pwrite_d    = pwrite;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_gnt;
                    gidx_d      = arb_idx;
                    ptr_d       = arb_idx;
                    psel_d      = 1'b1;
                    pwrite_d    = req_write[arb_idx];
                    paddr_d     = req_addr[int'(arb_idx)*AW +: AW];
                    pwdata_d    = req_wdata[int'(arb_idx)*DW +: DW];
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done        = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = (!pwrite && !pslverr) ? prdata : '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    done        = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = '0;
                    pwdata_d  = '0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                // response fields are cleared once the pulse has been seen
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge presetn) begin
        if (!presetn) begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a 16-entry APB RAM slave model.
module tb_apb_rr_master;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              presetn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW-1:0]     prdata;
    logic              pready, pslverr;

    logic              stall = 1'b0;
    logic [DW-1:0]     mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk(clk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Slave: zero-wait unless stalled, error on addresses outside 0..15.
    assign pready  = !stall;
    assign pslverr = psel && penable && (paddr >= 32'd16);
    assign prdata  = mem[paddr[3:0]];

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite && !pslverr)
            mem[paddr[3:0]] <= pwdata;
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h50 + 8'(i);
    end

    task automatic xfer(input int r, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [NREQ-1:0] rv,
                        output logic [DW-1:0] rd, output logic er, output bit to);
        rv = '0; rd = '0; er = 1'b0; to = 1'b1;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[r]) begin to = 1'b0; break; end
        end
        req_valid[r] = 1'b0;
        if (!to) begin
            to = 1'b1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (rsp_valid != '0) begin
                    rv = rsp_valid; rd = rsp_rdata; er = rsp_err; to = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset;
        presetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || req_ready !== 2'b00 ||
            rsp_valid !== 2'b00 || rsp_err !== 1'b0 || paddr !== 32'd0) begin
            errors++;
            $display("FAIL reset: psel=%b penable=%b req_ready=%b rsp_valid=%b err=%b paddr=%0h, required all 0",
                     psel, penable, req_ready, rsp_valid, rsp_err, paddr);
        end
        presetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [NREQ-1:0] rv; logic [DW-1:0] rd; logic er; bit to;
        @(negedge clk);
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[31:0] = 32'd3; req_wdata[7:0] = 8'hA5;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01 || psel !== 1'b1 || penable !== 1'b0) begin
            errors++;
            $display("FAIL wr_setup: req_ready=%b psel=%b penable=%b, required 01 1 0", req_ready, psel, penable);
        end
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (psel !== 1'b1 || penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 32'd3 || pwdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_access: psel=%b penable=%b pwrite=%b paddr=%0h pwdata=%0h, required 1 1 1 3 a5",
                     psel, penable, pwrite, paddr, pwdata);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00 || psel !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: rsp_valid=%b err=%b rdata=%0h psel=%b, required 01 0 0 0",
                     rsp_valid, rsp_err, rsp_rdata, psel);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL wr_resp_pulse: rsp_valid=%b, required 00", rsp_valid);
        end
        xfer(1, 1'b0, 32'd3, 8'h00, rv, rd, er, to);
        checks++;
        if (to || rv !== 2'b10 || rd !== 8'hA5 || er !== 1'b0) begin
            errors++;
            $display("FAIL rd_back: timeout=%0d rsp_valid=%b rdata=%0h err=%b, required 0 10 a5 0", to, rv, rd, er);
        end
    endtask

    task automatic test_round_robin;
        int gl[6]; int gc[6]; int n; int cyc;
        n = 0; cyc = 0;
        @(negedge clk);
        req_write = 2'b00;
        req_addr  = {32'd5, 32'd6};
        req_valid = 2'b11;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            cyc++;
            if (req_ready == 2'b01) begin gl[n] = 0; gc[n] = cyc; n++; end
            else if (req_ready == 2'b10) begin gl[n] = 1; gc[n] = cyc; n++; end
        end
        req_valid = 2'b00;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL rr_count: grants=%0d, required 6", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (gl[i] != (i % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: grant=%0d, required %0d", i, gl[i], i % 2);
            end
            if (i > 0) begin
                checks++;
                if (gc[i] - gc[i-1] != 4) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d]: cycles=%0d, required 4", i, gc[i] - gc[i-1]);
                end
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_slverr;
        logic [NREQ-1:0] rv; logic [DW-1:0] rd; logic er; bit to;
        xfer(1, 1'b0, 32'd20, 8'h00, rv, rd, er, to);
        checks++;
        if (to || rv !== 2'b10 || er !== 1'b1 || rd !== 8'h00) begin
            errors++;
            $display("FAIL slverr: timeout=%0d rsp_valid=%b err=%b rdata=%0h, required 0 10 1 0", to, rv, er, rd);
        end
    endtask

    task automatic test_timeout;
        int acc; bit got;
        acc = 0; got = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        req_write[0] = 1'b0; req_addr[31:0] = 32'd1; req_valid = 2'b01;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_ready[0]) req_valid = 2'b00;
            if (psel && penable) acc++;
            if (rsp_valid != '0) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || acc != 16) begin
            errors++;
            $display("FAIL timeout_len: got=%0d access_cycles=%0d, required 1 16", got, acc);
        end
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || psel !== 1'b0) begin
            errors++;
            $display("FAIL timeout_resp: rsp_valid=%b err=%b rdata=%0h psel=%b, required 01 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata, psel);
        end
        stall = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit seen; bit ok; logic [NREQ-1:0] first;
        seen = 1'b0; ok = 1'b0; first = '0;
        stall = 1'b1;
        @(negedge clk);
        req_write[0] = 1'b0; req_addr[31:0] = 32'd2; req_valid = 2'b01;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[0]) req_valid = 2'b00;
            if (psel && penable) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_access: never reached ACCESS, required penable=1");
        end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: psel=%b penable=%b, required 0 0", psel, penable);
        end
        repeat (2) @(negedge clk);
        presetn = 1'b1;
        stall = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rstmid_norsp: rsp_valid seen=1, required 0");
        end
        req_write = 2'b00; req_addr = {32'd7, 32'd8}; req_valid = 2'b11;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin first = req_ready; break; end
        end
        req_valid = 2'b00;
        checks++;
        if (first !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_ptr: first grant=%b, required 01", first);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_slverr();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
